// File: rtl/arm_pkg.sv
// Shared definitions for the execute/memory boundary: NZCV bit positions,
// the status flag struct, the EXE/MEM control bundle and the default
// destination-register index width.
package arm_pkg;

  localparam int N_BIT      = 3;
  localparam int Z_BIT      = 2;
  localparam int C_BIT      = 1;
  localparam int V_BIT      = 0;
  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } exe_mem_ctrl_t;

  function automatic nzcv_t make_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/status_reg.sv
// Architectural NZCV status register.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   we         : write enable; all four flags are written together
//   d          : new flags {N,Z,C,V}
//   q          : current flags {N,Z,C,V}
module status_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'b0000;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_status_stage.sv
// EXE/MEM pipeline register plus the NZCV status register.
// Captures the ALU result/flags and the executing instruction's control and
// store data, applies memory backpressure, global freeze and branch flush.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   freeze              : global hold, nothing changes
//   flush               : squash the instruction in EX
//   ex_valid, ex_s      : EX holds an instruction / it updates NZCV
//   ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_dest : EX control
//   alu_result, alu_n/z/c/v, ex_val_rm          : EX data and flags
//   mem_ready           : memory completes the current access this cycle
//   mem_*               : registered EXE/MEM outputs
//   status_nzcv         : {N,Z,C,V}; status_c is its C bit (registered only)
//   exe_stall           : backpressure to upstream stages
//   stall_cycles        : saturating stall-cycle count, only present when
//                         EXE_STALL_COUNTER_EN is defined
module exe_mem_status_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_s,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic                  ex_mem_w_en,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v,
  input  logic [DATA_W-1:0]     ex_val_rm,
  input  logic                  mem_ready,
  output logic                  mem_valid,
  output logic                  mem_wb_en,
  output logic                  mem_mem_r_en,
  output logic                  mem_mem_w_en,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     mem_val_rm,
  output logic [3:0]            status_nzcv,
  output logic                  status_c,
`ifdef EXE_STALL_COUNTER_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic                  exe_stall
);

  import arm_pkg::*;

  exe_mem_ctrl_t ctrl_q;
  nzcv_t         flags_in;
  logic          mem_busy;
  logic          accept;
  logic          status_we;

  // Only an outstanding load/store can hold the stage; ALU ops in MEM never do.
  assign mem_busy  = ctrl_q.valid & (ctrl_q.mem_r_en | ctrl_q.mem_w_en) & ~mem_ready;
  assign exe_stall = mem_busy | freeze;
  assign accept    = ~exe_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q         <= '0;
      mem_dest       <= '0;
      mem_alu_result <= '0;
      mem_val_rm     <= '0;
    end else if (accept) begin
      mem_dest       <= ex_dest;
      mem_alu_result <= alu_result;
      mem_val_rm     <= ex_val_rm;
      if (flush || !ex_valid) begin
        ctrl_q <= '0;
      end else begin
        ctrl_q.valid    <= 1'b1;
        ctrl_q.wb_en    <= ex_wb_en;
        ctrl_q.mem_r_en <= ex_mem_r_en;
        ctrl_q.mem_w_en <= ex_mem_w_en;
      end
    end
  end

  assign mem_valid    = ctrl_q.valid;
  assign mem_wb_en    = ctrl_q.wb_en;
  assign mem_mem_r_en = ctrl_q.mem_r_en;
  assign mem_mem_w_en = ctrl_q.mem_w_en;

  // All four flags are written: logical ops drive C/V to 0 in the ALU.
  assign flags_in  = make_nzcv(alu_n, alu_z, alu_c, alu_v);
  assign status_we = accept & ex_valid & ~flush & ex_s;

  status_reg u_status_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (status_we),
    .d     (flags_in),
    .q     (status_nzcv)
  );

  // Taken from the register so ADC/SBC never see a combinational carry loop.
  assign status_c = status_nzcv[C_BIT];

`ifdef EXE_STALL_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (exe_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_status_stage.sv
module tb_exe_mem_status_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0, ex_s = 1'b0, ex_wb_en = 1'b0;
  logic        ex_mem_r_en = 1'b0, ex_mem_w_en = 1'b0;
  logic [3:0]  ex_dest = '0;
  logic [31:0] alu_result = '0, ex_val_rm = '0;
  logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic        mem_ready = 1'b1;

  logic        mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_val_rm;
  logic [3:0]  status_nzcv;
  logic        status_c, exe_stall;
`ifdef EXE_STALL_COUNTER_EN
  logic [31:0] stall_cycles;
`endif

  exe_mem_status_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_dest(ex_dest),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .alu_v(alu_v), .ex_val_rm(ex_val_rm), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en),
    .mem_mem_w_en(mem_mem_w_en), .mem_dest(mem_dest),
    .mem_alu_result(mem_alu_result), .mem_val_rm(mem_val_rm),
    .status_nzcv(status_nzcv), .status_c(status_c),
`ifdef EXE_STALL_COUNTER_EN
    .stall_cycles(stall_cycles),
`endif
    .exe_stall(exe_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, wb, r, w;
    logic [3:0]  dest;
    logic [31:0] res, rm;
    logic [3:0]  nzcv;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m = '0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic wb, input logic r,
                       input logic w, input logic [3:0] dest, input logic [31:0] res,
                       input logic [31:0] rm, input logic [3:0] f);
    ex_valid = v; ex_s = s; ex_wb_en = wb; ex_mem_r_en = r; ex_mem_w_en = w;
    ex_dest = dest; alu_result = res; ex_val_rm = rm;
    {alu_n, alu_z, alu_c, alu_v} = f;
  endtask

  // Predict the next-state from the model and current inputs, push it, clock,
  // then pop and compare against the DUT.
  task automatic step();
    exp_t e;
    logic stall;
    stall = (m.valid & (m.r | m.w) & ~mem_ready) | freeze;
    #1;
    chk("exe_stall", {31'd0, exe_stall}, {31'd0, stall});
    e = m;
    if (!stall) begin
      e.dest = ex_dest; e.res = alu_result; e.rm = ex_val_rm;
      if (flush || !ex_valid) begin
        e.valid = 0; e.wb = 0; e.r = 0; e.w = 0;
      end else begin
        e.valid = 1; e.wb = ex_wb_en; e.r = ex_mem_r_en; e.w = ex_mem_w_en;
        if (ex_s) e.nzcv = {alu_n, alu_z, alu_c, alu_v};
      end
    end
    if (stall && e.cnt != 32'hFFFF_FFFF) e.cnt = e.cnt + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, e.valid});
    chk("mem_ctrl", {29'd0, mem_wb_en, mem_mem_r_en, mem_mem_w_en}, {29'd0, e.wb, e.r, e.w});
    chk("mem_dest", {28'd0, mem_dest}, {28'd0, e.dest});
    chk("mem_alu_result", mem_alu_result, e.res);
    chk("mem_val_rm", mem_val_rm, e.rm);
    chk("status_nzcv", {28'd0, status_nzcv}, {28'd0, e.nzcv});
    chk("status_c", {31'd0, status_c}, {31'd0, e.nzcv[1]});
`ifdef EXE_STALL_COUNTER_EN
    chk("stall_cycles", stall_cycles, e.cnt);
`endif
    m = e;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_status", {28'd0, status_nzcv}, 32'd0);
    chk("rst_exe_stall", {31'd0, exe_stall}, 32'd0);

    // load with flags 1011
    drive(1, 1, 1, 0, 0, 4'd3, 32'h8000_0000, 32'h1111_0000, 4'b1011);
    step();
    chk("lf_result", mem_alu_result, 32'h8000_0000);
    chk("lf_status", {28'd0, status_nzcv}, 32'hB);
    chk("lf_c", {31'd0, status_c}, 32'd1);

    // no S bit: status holds
    drive(1, 0, 1, 0, 0, 4'd5, 32'h0000_1234, 32'h2222_0000, 4'b0100);
    step();
    chk("nos_status", {28'd0, status_nzcv}, 32'hB);
    chk("nos_result", mem_alu_result, 32'h0000_1234);

    // flush
    flush = 1'b1;
    drive(1, 1, 1, 0, 0, 4'd6, 32'h0, 32'h0, 4'b0001);
    step();
    chk("fl_valid", {31'd0, mem_valid}, 32'd0);
    chk("fl_wb", {31'd0, mem_wb_en}, 32'd0);
    chk("fl_status", {28'd0, status_nzcv}, 32'hB);
    flush = 1'b0;

    // memory backpressure: load enters MEM, memory not ready for 3 cycles
    drive(1, 0, 1, 1, 0, 4'd7, 32'h0000_0100, 32'h0, 4'b0000);
    step();
    mem_ready = 1'b0;
    drive(1, 1, 1, 0, 0, 4'd8, 32'h0000_0200, 32'h3, 4'b0110);
    repeat (3) step();
    chk("bp_status", {28'd0, status_nzcv}, 32'hB);
    chk("bp_result", mem_alu_result, 32'h0000_0100);
    mem_ready = 1'b1;
    step();
    chk("bp_rel_status", {28'd0, status_nzcv}, 32'h6);
    chk("bp_rel_dest", {28'd0, mem_dest}, 32'd8);
    drive(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'b0000);
    step();

    // non-memory op in MEM never stalls
    drive(1, 0, 1, 0, 0, 4'd9, 32'h55, 32'h0, 4'b0000);
    step();
    mem_ready = 1'b0;
    drive(1, 0, 1, 0, 0, 4'd10, 32'h66, 32'h0, 4'b0000);
    step();
    chk("nm_stall", {31'd0, exe_stall}, 32'd0);
    mem_ready = 1'b1;

    // freeze with flush: nothing moves
    freeze = 1'b1; flush = 1'b1;
    drive(1, 1, 1, 0, 1, 4'd11, 32'hDEAD_BEEF, 32'h7, 4'b1111);
    repeat (2) step();
    chk("fz_result", mem_alu_result, 32'h66);
    freeze = 1'b0; flush = 1'b0;

    // randomised traffic
    for (int i = 0; i < 60; i++) begin
      freeze    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    freeze = 1'b0; flush = 1'b0; mem_ready = 1'b1;

    // reset in the middle of a memory stall
    drive(1, 1, 1, 0, 1, 4'd12, 32'h44, 32'h88, 4'b1001);
    step();
    mem_ready = 1'b0;
    drive(1, 0, 0, 0, 0, 4'd1, 32'h1, 32'h1, 4'b0000);
    step();
    chk("pre_rst_stall", {31'd0, exe_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, mem_valid}, 32'd0);
    chk("ar_stall", {31'd0, exe_stall}, 32'd0);
    chk("ar_status", {28'd0, status_nzcv}, 32'd0);
    chk("ar_result", mem_alu_result, 32'd0);
    chk("ar_ctrl", {28'd0, mem_wb_en, mem_mem_r_en, mem_mem_w_en, status_c}, 32'd0);
`ifdef EXE_STALL_COUNTER_EN
    chk("ar_cnt", stall_cycles, 32'd0);
`endif
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 4'b0000);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 4'd2, 32'h0, 32'h0, 4'b0100);
    step();
    chk("post_rst_status", {28'd0, status_nzcv}, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

endmodule

// File: doc/exe_mem_status_stage.md
Name: exe_mem_status_stage

Overview:
- Sequential stage directly downstream of the execute-stage ALU. Captures the ALU result and flags, plus the pipelined control/data of the executing instruction, into the EXE/MEM pipeline register.
- Owns the architectural NZCV status register. Its C bit feeds back to the ALU carry input for ADC/SBC.
- Handles memory-ready backpressure, global freeze and branch flush.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data).
- REG_ADDR_W, 4, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  global hold; no register changes
- flush  in  1  squash the instruction currently in EX (taken branch)
- ex_valid  in  1  EX stage holds a real instruction
- ex_s  in  1  instruction's S bit; update NZCV
- ex_wb_en  in  1  writeback enable
- ex_mem_r_en  in  1  load
- ex_mem_w_en  in  1  store
- ex_dest  in  REG_ADDR_W  destination register
- alu_result  in  DATA_W  ALU output
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags
- ex_val_rm  in  DATA_W  store data
- mem_ready  in  1  memory stage completes the current access this cycle
- mem_valid  out  1  MEM register holds a real instruction
- mem_wb_en, mem_mem_r_en, mem_mem_w_en  out  1 each  registered control
- mem_dest  out  REG_ADDR_W  registered destination
- mem_alu_result  out  DATA_W  registered result / address
- mem_val_rm  out  DATA_W  registered store data
- status_nzcv  out  4  status register, bit3=N, bit2=Z, bit1=C, bit0=V
- status_c  out  1  status_nzcv[1], to ALU carry input
- exe_stall  out  1  backpressure to upstream stages

Behaviour:
- Reset (async, rst_n=0): all outputs and registers are 0, including status_nzcv=4'b0000.
- mem_busy = mem_valid & (mem_mem_r_en | mem_mem_w_en) & ~mem_ready. This is combinational from registered state and mem_ready.
- exe_stall = mem_busy | freeze (combinational).
- accept = ~freeze & ~mem_busy.
- Priority on each clock edge: reset > hold (~accept) > flush/bubble > load.
- Hold: every register keeps its value. Status is not updated even if ex_s=1; the instruction stays upstream and is re-presented.
- On accept with (flush | ~ex_valid):
  - mem_valid, mem_wb_en, mem_mem_r_en and mem_mem_w_en are set to 0.
  - mem_dest, mem_alu_result and mem_val_rm load the inputs; these fields are don't-care when mem_valid=0.
- On accept with ex_valid & ~flush:
  - All MEM fields load the inputs; mem_valid=1.
  - Latency: 1 cycle, EX inputs to MEM outputs.
- Status update: status_nzcv <= {alu_n, alu_z, alu_c, alu_v} iff accept & ex_valid & ~flush & ex_s. Otherwise status_nzcv holds.
  - All four bits are written, since the ALU defines C/V as 0 for logical ops.
- status_c is registered only; there is no combinational path from alu_c to status_c. This prevents an ADC loop.
- Simultaneous flush & freeze: freeze wins; the flush must be re-asserted by the branch logic on the next non-frozen cycle.
- Simultaneous flush & mem_busy: hold wins, same rule as freeze.
- Non-memory instructions in MEM never cause stall, regardless of mem_ready.
- Reset asserted mid-stall: immediate clear; exe_stall drops asynchronously with mem_valid.

Optional Feature:
- Macro: EXE_STALL_COUNTER_EN.
- Defined:
  - Adds output stall_cycles, 32 bits.
  - Reset value 0.
  - Increments by 1 on every clock edge where exe_stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Not affected by flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package arm_pkg:
  - NZCV bit-index constants (N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0).
  - Packed struct nzcv_t.
  - Packed struct exe_mem_ctrl_t {valid, wb_en, mem_r_en, mem_w_en}.
  - REG_ADDR_W constant.
- Sub-module status_reg: 4-bit NZCV register with async active-low reset and write enable, instantiated once.

Test Plan:
- Reset: rst_n=0 mid-run with mem_valid=1 -> all outputs 0 asynchronously, status_nzcv=0000, exe_stall=0.
- Load + flags: ex_valid=1, ex_s=1, alu_result=32'h8000_0000, n=1 z=0 c=1 v=1 -> next cycle mem_alu_result=32'h8000_0000, mem_valid=1, status_nzcv=1011, status_c=1.
- No S bit: ex_s=0, flags 0100 after status=1011 -> status_nzcv stays 1011; MEM fields update.
- Flush: flush=1 with ex_valid=1, ex_s=1, ex_wb_en=1 -> mem_valid=0, mem_wb_en=0, status unchanged.
- Memory backpressure: load in MEM, mem_ready=0 for 3 cycles, new ex_s=1 instruction waiting -> exe_stall=1 for 3 cycles, MEM regs and status frozen; with mem_ready=1 the waiting instruction loads next edge and status updates once.
- Freeze vs flush: freeze=1 & flush=1 together -> no change anywhere; with EXE_STALL_COUNTER_EN, stall_cycles increments by exactly 1 per frozen cycle.
